// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, data width and bit-period helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrapping pointers and a registered occupancy count.
// Push is gated by full and pop by empty, both evaluated before this cycle's update.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: CPU writes fill a FIFO that the serial FSM drains back-to-back.
// Define UART_TX_CTS_EN to add an active-low cts_n input that gates the start of new frames.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 64_000_000,
    parameter int BIT_RATE = 115_200,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       clr_overflow,
`ifdef UART_TX_CTS_EN
    input  logic                       cts_n,
`endif
    output logic                       uart_txd,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       busy
);
    localparam int CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int DIV_W = $clog2(CPB);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CPB - 1);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(UART_DATA_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;
    logic                      overflow_q, overflow_d;
    logic                      pop, fifo_empty, can_send, bit_done;
    logic [7:0]                fifo_rd_data;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (fifo_empty),
        .count   (level)
    );

`ifdef UART_TX_CTS_EN
    assign can_send = !fifo_empty && !cts_n;
`else
    assign can_send = !fifo_empty;
`endif

    assign bit_done = (div_q == '0);
    assign uart_txd = txd_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || (level != '0);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (can_send) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    txd_d   = 1'b0;
                    div_d   = DIV_MAX;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                    div_d     = DIV_MAX;
                    state_d   = DATA;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            DATA: begin
                // The shifter always holds the next bit to send in position 0.
                if (bit_done) begin
                    div_d = DIV_MAX;
                    if (bit_idx_q == BIT_LAST) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            STOP: begin
                if (bit_done) state_d = IDLE;
                else          div_d   = div_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // A dropped write in the same cycle as a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow)  overflow_d = 1'b0;
        if (wr_en && full) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: scenario tasks plus a serial-line monitor
// that decodes frames and compares them against a scoreboard of accepted bytes.
module tb_uart_tx_buffered;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB + 1;

    logic       clk, rst, wr_en, clr_overflow, cts_n;
    logic [7:0] wr_data;
    logic       uart_txd, full, overflow, busy;
    logic [3:0] level;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b1;
    logic [7:0] sb[$];
    int         starts[$];

    uart_tx_buffered #(
        .CLK_HZ   (16),
        .BIT_RATE (1),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
`ifdef UART_TX_CTS_EN
        .cts_n        (cts_n),
`endif
        .uart_txd     (uart_txd),
        .full         (full),
        .level        (level),
        .overflow     (overflow),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples mid-bit, checks framing and compares data to the scoreboard.
    initial begin
        logic [7:0] got, exp_b;
        bit         bad;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && uart_txd === 1'b0) begin
                starts.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                bad = (uart_txd !== 1'b0);
                got = '0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = uart_txd;
                end
                repeat (CPB) @(negedge clk);
                bad = bad || (uart_txd !== 1'b1);
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL frame_unexpected got=%02h expected=none", got);
                end else begin
                    exp_b = sb.pop_front();
                    if (bad || got !== exp_b) begin
                        failures++;
                        $display("FAIL frame_data got=%02h expected=%02h framing_err=%0d", got, exp_b, bad);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout busy=%b expected=0 after %0d cycles", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_overflow = 1'b0; cts_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({uart_txd, full, level, overflow, busy} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state txd=%b full=%b level=%0d ovf=%b busy=%b expected 1 0 0 0 0",
                     uart_txd, full, level, overflow, busy);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] line = 10'b1101001010;
        int busy_cnt;
        bit bad;
        starts.delete();
        wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        busy_cnt = busy ? 1 : 0;
        checks++;
        if (uart_txd !== 1'b1 || level !== 4'd1) begin
            failures++;
            $display("FAIL single_push_edge txd=%b level=%0d expected txd=1 level=1", uart_txd, level);
        end
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                busy_cnt += busy ? 1 : 0;
                if (uart_txd !== line[b]) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL single_bit%0d line deviated expected=%b for %0d cycles", b, line[b], CPB);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || busy_cnt != 161 || uart_txd !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_len busy=%b high_cycles=%0d txd=%b expected busy=0 161 txd=1",
                     busy, busy_cnt, uart_txd);
        end
    endtask

    task automatic test_burst_overflow();
        starts.delete();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            if (i < 9) sb.push_back(8'(i));
            @(negedge clk);
            if (i == 8) begin
                checks++;
                if (full !== 1'b1 || overflow !== 1'b0 || level !== 4'd8) begin
                    failures++;
                    $display("FAIL burst_9th full=%b ovf=%b level=%0d expected 1 0 8", full, overflow, level);
                end
            end
            if (i == 9) begin
                checks++;
                if (full !== 1'b1 || overflow !== 1'b1 || level !== 4'd8) begin
                    failures++;
                    $display("FAIL burst_drop full=%b ovf=%b level=%0d expected 1 1 8", full, overflow, level);
                end
            end
        end
        wr_en = 1'b0;
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear ovf=%b expected=0", overflow);
        end
        clr_overflow = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        clr_overflow = 1'b0; wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || level !== 4'd8) begin
            failures++;
            $display("FAIL ovf_set_wins ovf=%b level=%0d expected 1 8", overflow, level);
        end
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        wait_idle(12 * FRAME, "burst_drain");
        checks++;
        if (starts.size() != 9) begin
            failures++;
            $display("FAIL burst_frames got=%0d expected=9", starts.size());
        end else begin
            for (int i = 1; i < 9; i++) begin
                checks++;
                if (starts[i] - starts[i-1] != FRAME) begin
                    failures++;
                    $display("FAIL burst_gap%0d spacing=%0d expected=%0d", i, starts[i] - starts[i-1], FRAME);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        mon_en = 1'b0;
        wr_en = 1'b1; wr_data = 8'h3C;
        @(negedge clk);
        wr_data = 8'h11;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (70) @(negedge clk);
        checks++;
        if (uart_txd !== 1'b1 || level !== 4'd1) begin
            failures++;
            $display("FAIL rst_pre_bit3 txd=%b level=%0d expected 1 1", uart_txd, level);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (uart_txd !== 1'b1 || level !== 4'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_frame txd=%b level=%0d busy=%b ovf=%b expected 1 0 0 0",
                     uart_txd, level, busy, overflow);
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        wr_en = 1'b1; wr_data = 8'h55; sb.push_back(8'h55);
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle(2 * FRAME, "rst_recover");
    endtask

    task automatic test_push_pop_same();
        int n = 0;
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i); sb.push_back(8'h10 + 8'(i));
            @(negedge clk);
        end
        wr_en = 1'b0;
        while (level !== 4'd7 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (level !== 4'd7) begin
            failures++;
            $display("FAIL pp_first_pop_timeout level=%0d expected=7", level);
        end
        repeat (FRAME - 1) @(negedge clk);
        checks++;
        if (uart_txd !== 1'b1 || level !== 4'd7) begin
            failures++;
            $display("FAIL pp_pre_edge txd=%b level=%0d expected 1 7", uart_txd, level);
        end
        wr_en = 1'b1; wr_data = 8'h77; sb.push_back(8'h77);
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (level !== 4'd7 || overflow !== 1'b0 || uart_txd !== 1'b0) begin
            failures++;
            $display("FAIL pp_same_cycle level=%0d ovf=%b txd=%b expected 7 0 0", level, overflow, uart_txd);
        end
        wait_idle(10 * FRAME, "pp_drain");
    endtask

`ifdef UART_TX_CTS_EN
    task automatic test_cts();
        bit bad = 1'b0;
        cts_n = 1'b1;
        wr_en = 1'b1; wr_data = 8'h21; sb.push_back(8'h21);
        @(negedge clk);
        wr_data = 8'h22; sb.push_back(8'h22);
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad || busy !== 1'b1 || level !== 4'd2) begin
            failures++;
            $display("FAIL cts_hold line_low=%b busy=%b level=%0d expected 0 1 2", bad, busy, level);
        end
        cts_n = 1'b0;
        @(negedge clk);
        checks++;
        if (uart_txd !== 1'b0 || level !== 4'd1) begin
            failures++;
            $display("FAIL cts_release txd=%b level=%0d expected 0 1", uart_txd, level);
        end
        repeat (40) @(negedge clk);
        cts_n = 1'b1;
        repeat (150) @(negedge clk);
        checks++;
        if (uart_txd !== 1'b1 || level !== 4'd1 || busy !== 1'b1 || sb.size() != 1) begin
            failures++;
            $display("FAIL cts_mid_frame txd=%b level=%0d busy=%b pending=%0d expected 1 1 1 1",
                     uart_txd, level, busy, sb.size());
        end
        cts_n = 1'b0;
        wait_idle(2 * FRAME, "cts_drain");
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_burst_overflow();
        test_reset_mid_frame();
        do_reset();
        test_push_pop_same();
`ifdef UART_TX_CTS_EN
        do_reset();
        test_cts();
`endif
        repeat (CPB) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
